// File: rtl/amcal3_pkg.sv
// Shared widths, the S1 payload record and the saturating beat-count helper
// for the AMCAL3 product reconstruction back end.
package amcal3_pkg;

  localparam int MANT_W    = 3;
  localparam int SHIFT_W   = 4;
  localparam int PROD_W    = 32;
  localparam int TRUNC_LSB = 4;
  localparam int MPROD_W   = 2 * MANT_W;
  localparam int SSUM_W    = SHIFT_W + 1;
  localparam int CNT_W     = 5;

  typedef struct packed {
    logic [MPROD_W-1:0] mprod;
    logic [SSUM_W-1:0]  ssum;
    logic               zero;
    logic               last;
  } s1_t;

  // Beat counter saturates at its all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/amcal3_barrel_shl.sv
// Combinational product rebuild: mantissa product shifted left by the summed
// leading-one positions, with the four fractional LSBs truncated away.
module amcal3_barrel_shl
  import amcal3_pkg::*;
(
  input  logic [MPROD_W-1:0] mprod,
  input  logic [SSUM_W-1:0]  ssum,
  output logic [PROD_W-1:0]  prod
);

  localparam int WIDE_W = PROD_W + TRUNC_LSB;

  // 6-bit product shifted up to 30 fits exactly in 36 bits; drop the low 4.
  always_comb begin
    prod = PROD_W'((WIDE_W'(mprod) << ssum) >> TRUNC_LSB);
  end

endmodule

// File: rtl/amcal3_product_reconstruct.sv
// AMCAL3 back end: three-stage pipeline (mantissa multiply, barrel shift,
// group accumulate) under a single global stall driven by the output port.
module amcal3_product_reconstruct
  import amcal3_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MANT_W-1:0]    a,
  input  logic [MANT_W-1:0]    b,
  input  logic [SHIFT_W-1:0]   ashift,
  input  logic [SHIFT_W-1:0]   bshift,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic [CNT_W-1:0]     out_count
);

  logic              adv;
  s1_t               s1_q;
  logic              s1_valid;
  logic [PROD_W-1:0] shl_prod;
  logic [PROD_W-1:0] p_q;
  logic              s2_last;
  logic              s2_valid;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_next;

  // Whole pipeline moves together; it only freezes on an unconsumed result.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
    acc_sum  = acc + ACC_W'(p_q);
    cnt_next = sat_inc(cnt);
  end

  // S1: mantissa product, shift sum and zero-operand flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_q.mprod  <= MPROD_W'(a) * MPROD_W'(b);
      s1_q.ssum   <= SSUM_W'(ashift) + SSUM_W'(bshift);
      s1_q.zero   <= !(a[MANT_W-1] && b[MANT_W-1]);
      s1_q.last   <= in_last;
    end
  end

  amcal3_barrel_shl u_shl (
    .mprod (s1_q.mprod),
    .ssum  (s1_q.ssum),
    .prod  (shl_prod)
  );

  // S2: reconstructed 32-bit product, forced to zero for a zero operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      s2_last  <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      p_q      <= s1_q.zero ? '0 : shl_prod;
      s2_last  <= s1_q.last;
      s2_valid <= s1_valid;
    end
  end

  // Accumulate stage: sum the group, publish on the last beat and restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          out_data  <= acc_sum;
          out_count <= cnt_next;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_amcal3_product_reconstruct.sv
// Randomized and directed bench for amcal3_product_reconstruct with an
// arithmetic reference model and an in-order result scoreboard.
module tb_amcal3_product_reconstruct;

  localparam int ACC_W = 40;
  localparam longint ACC_MASK = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       a = '0;
  logic [2:0]       b = '0;
  logic [3:0]       ashift = '0;
  logic [3:0]       bshift = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_data;
  logic [4:0]       out_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    longint data;
    int     cnt;
  } exp_t;

  exp_t   q[$];
  longint m_sum = 0;
  int     m_cnt = 0;
  bit     accepted;

  amcal3_product_reconstruct #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ashift    (ashift),
    .bshift    (bshift),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Operand value is mant * 2^shift / 4; product is the truncated integer.
  function automatic longint ref_prod(int ma, int mb, int sa, int sb);
    if (ma < 4 || mb < 4) return 0;
    return (longint'(ma * mb) * (longint'(1) << (sa + sb))) / 16;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_accept();
    longint p;
    p = ref_prod(int'(a), int'(b), int'(ashift), int'(bshift));
    m_sum = (m_sum + p) & ACC_MASK;
    m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
    if (in_last) begin
      q.push_back('{data: m_sum, cnt: m_cnt});
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sum = 0;
    m_cnt = 0;
  endtask

  // One clock: sample both handshakes at the falling edge, return just after
  // the next rising edge.
  task automatic step();
    @(negedge clk);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("sb_extra_out", longint'(out_valid), 0);
      end else begin
        chk("sb_data", longint'(out_data), q[0].data);
        chk("sb_count", longint'(out_count), longint'(q[0].cnt));
        if (out_ready) void'(q.pop_front());
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int ma, input int sa, input int mb, input int sb, input bit last);
    a       = 3'(ma);
    ashift  = 4'(sa);
    b       = 3'(mb);
    bshift  = 4'(sb);
    in_last = last;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      if (n == 3) out_ready = 1'b1;
      step();
    end
    chk("beat_accept", longint'(accepted), 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int max);
    for (int n = 0; n < max && !out_valid; n++) step();
    chk("wait_out", longint'(out_valid), 1);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_count", longint'(out_count), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat group and its latency
    beat(4, 0, 4, 0, 1);
    idle();
    chk("lat_edge_k", longint'(out_valid), 0);
    step();
    chk("lat_edge_k1", longint'(out_valid), 0);
    step();
    chk("lat_edge_k2", longint'(out_valid), 1);
    chk("single_data", longint'(out_data), 1);
    chk("single_count", longint'(out_count), 1);

    // Two-beat group with large shifts
    beat(6, 3, 5, 4, 0);
    beat(7, 15, 7, 15, 1);
    idle();
    wait_out(10);
    chk("pair_data", longint'(out_data), 64'd3288334576);
    chk("pair_count", longint'(out_count), 2);

    // Zero operand
    beat(0, 9, 7, 15, 1);
    idle();
    wait_out(10);
    chk("zero_data", longint'(out_data), 0);
    chk("zero_count", longint'(out_count), 1);
    step();

    // Backpressure: result held, input stalled, nothing lost or repeated
    out_ready = 1'b0;
    beat(4, 1, 4, 1, 1);
    a = 3'd5; ashift = 4'd2; b = 3'd6; bshift = 4'd3; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("bp_in_ready", longint'(in_ready), 0);
    chk("bp_out_valid", longint'(out_valid), 1);
    chk("bp_held_data", longint'(out_data), 4);
    out_ready = 1'b1;
    beat(7, 1, 4, 2, 1);
    idle();
    for (int i = 0; i < 8; i++) step();
    chk("bp_drained", longint'(q.size()), 0);
    chk("bp_idle_valid", longint'(out_valid), 0);

    // Reset in the middle of a group
    beat(7, 10, 6, 11, 0);
    beat(5, 3, 7, 2, 0);
    beat(6, 14, 4, 1, 0);
    idle();
    step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_out_data", longint'(out_data), 0);
    chk("mid_rst_out_count", longint'(out_count), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat(4, 0, 4, 0, 1);
    idle();
    wait_out(10);
    chk("post_rst_data", longint'(out_data), 1);
    chk("post_rst_count", longint'(out_count), 1);

    // 40 back-to-back unit products: count saturates, sum does not
    for (int i = 0; i < 40; i++) beat(4, 0, 4, 0, i == 39);
    idle();
    wait_out(10);
    chk("sat_data", longint'(out_data), 40);
    chk("sat_count", longint'(out_count), 31);
    step();

    // Random traffic with random output backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        idle();
        step();
      end else begin
        beat(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0));
      end
    end
    out_ready = 1'b1;
    beat(int'($urandom_range(4, 7)), int'($urandom_range(0, 15)),
         int'($urandom_range(4, 7)), int'($urandom_range(0, 15)), 1'b1);
    idle();
    for (int i = 0; i < 10; i++) step();
    chk("rand_drained", longint'(q.size()), 0);
    chk("rand_idle_valid", longint'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
